// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width: clog2(N), never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_adder_if.sv
// Request/result bundle between a client and the shared seq_adder unit.
interface seq_adder_if #(parameter int WIDTH = 16);

    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    // start is accepted on a rising edge whenever busy is low (IDLE or DONE);
    // while busy is high start is ignored and a/b/cin/sub may change freely.
    // done is a one-cycle pulse; s/cout/ovf hold until the next completion.
    modport master (
        output start, sub, cin, a, b,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, s, cout, ovf
    );

endinterface

// File: rtl/fulladd.sv
// Single-bit combinational full-adder cell.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_adder_digit_add.sv
// DIGIT-bit ripple adder made of chained fulladd cells.
module digit_add #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = ci;
    assign co   = c[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        fulladd u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit ripple stage reused over
// WIDTH/DIGIT cycles, with a start/done handshake.
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_adder_if.slave   bus,
    output state_t       dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] opa, opb, acc, acc_nx, s_q;
    logic [CW-1:0]    cnt;
    logic             carry, cout_q, ovf_q, a_msb, b_msb;
    logic [DIGIT-1:0] dsum;
    logic             dco;
    logic             accept, last;

    assign accept = (state != RUN) && bus.start;
    assign last   = (cnt == LAST);

    digit_add #(.DIGIT(DIGIT)) u_digit (
        .x   (opa[DIGIT-1:0]),
        .y   (opb[DIGIT-1:0]),
        .ci  (carry),
        .sum (dsum),
        .co  (dco)
    );

    // New digit enters at the MSB end; after N shifts digit 0 sits at the LSB.
    assign acc_nx = (acc >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = bus.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + ~borrow, so only the B side is inverted.
            opa   <= bus.a;
            opb   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ^ bus.cin;
            cnt   <= '0;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.sub ^ bus.b[WIDTH-1];
        end else if (state == RUN) begin
            opa   <= opa >> DIGIT;
            opb   <= opb >> DIGIT;
            carry <= dco;
            acc   <= acc_nx;
            cnt   <= cnt + 1'b1;
            if (last) begin
                s_q    <= acc_nx;
                cout_q <= dco;
                ovf_q  <= (a_msb == b_msb) && (acc_nx[WIDTH-1] != a_msb);
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.s     = s_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: three instances (DIGIT 1, 4, 16) share one stimulus
// stream and are checked against a plain-arithmetic reference.
module tb_seq_adder;
    import seq_adder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    seq_adder_if #(.WIDTH(16)) if1 ();
    seq_adder_if #(.WIDTH(16)) if4 ();
    seq_adder_if #(.WIDTH(16)) if16 ();
    state_t st1, st4, st16;

    assign if1.start = start;  assign if1.sub = sub;  assign if1.cin = cin;
    assign if1.a = a;          assign if1.b = b;
    assign if4.start = start;  assign if4.sub = sub;  assign if4.cin = cin;
    assign if4.a = a;          assign if4.b = b;
    assign if16.start = start; assign if16.sub = sub; assign if16.cin = cin;
    assign if16.a = a;         assign if16.b = b;

    seq_adder #(.WIDTH(16), .DIGIT(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1),  .dbg_state(st1));
    seq_adder #(.WIDTH(16), .DIGIT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4),  .dbg_state(st4));
    seq_adder #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16), .dbg_state(st16));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [17:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {cout, ovf, s} from integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] va, input logic [15:0] vb,
                                         input logic vc, input logic vs);
        int ua, ub, sa, sb, ci, r, sr;
        logic co, ov;
        ua = va; ub = vb; ci = vc;
        sa = $signed(va); sb = $signed(vb);
        if (!vs) begin
            r  = ua + ub + ci;
            sr = sa + sb + ci;
            co = (r > 65535);
        end else begin
            r  = ua - ub - ci;
            sr = sa - sb - ci;
            co = (ua >= ub + ci);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {co, ov, r[15:0]};
    endfunction

    // ---------------- driver ----------------
    int lat1, lat4, lat16, hi4;

    task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic vs);
        @(negedge clk);
        a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat1 = 0; lat4 = 0; lat16 = 0; hi4 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if1.done && lat1 == 0) lat1 = c;
            if (if4.done && lat4 == 0) lat4 = c;
            if (if16.done && lat16 == 0) lat16 = c;
            if (if4.done) hi4++;
            if (lat1 != 0 && lat4 != 0 && lat16 != 0) break;
        end
    endtask

    task automatic settle();
        start = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    logic [15:0] ta[6]    = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0010};
    logic [15:0] tb_v[6]  = '{16'h0FCD, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001};
    logic        tcin[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        tsub[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] ts[6]    = '{16'h2201, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h000E};
    logic        tcout[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        tovf[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, nd;
        logic [15:0] s_d1, s_d2;
        logic ovf_d2;
        logic [17:0] e;

        repeat (3) @(negedge clk);
        check_val("rst_busy", if4.busy, 0);
        check_val("rst_done", if4.done, 0);
        check_val("rst_s", if4.s, 0);
        check_val("rst_flags", {if4.cout, if4.ovf}, 0);
        check_val("rst_state", st4, IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors on the default instance
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb_v[i], tcin[i], tsub[i]);
            check_val($sformatf("dir%0d_s", i), if4.s, ts[i]);
            check_val($sformatf("dir%0d_cout", i), if4.cout, tcout[i]);
            check_val($sformatf("dir%0d_ovf", i), if4.ovf, tovf[i]);
            check_val($sformatf("dir%0d_lat", i), lat4, 4);
            check_val($sformatf("dir%0d_done_width", i), hi4, 1);
        end

        // start pulsed mid-operation is ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h0FCD; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        d1 = 0; nd = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 2) begin
                a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (if4.done) begin
                nd++;
                if (d1 == 0) d1 = c;
            end
        end
        check_val("ignore_lat", d1, 4);
        check_val("ignore_done_count", nd, 1);
        check_val("ignore_s", if4.s, 16'h2201);
        settle();

        // start held through DONE: back-to-back second operation
        @(negedge clk);
        a = 16'h1234; b = 16'h0FCD; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        d1 = 0; d2 = 0; s_d1 = '0; s_d2 = '0; ovf_d2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin
                a = 16'h7FFF; b = 16'h0001;
            end
            if (c >= 5) start = 1'b0;
            if (if4.done) begin
                if (d1 == 0) begin
                    d1 = c; s_d1 = if4.s;
                end else if (d2 == 0) begin
                    d2 = c; s_d2 = if4.s; ovf_d2 = if4.ovf;
                end
            end
        end
        check_val("b2b_first_lat", d1, 4);
        check_val("b2b_first_s", s_d1, 16'h2201);
        check_val("b2b_second_gap", d2 - d1, 5);
        check_val("b2b_second_s", s_d2, 16'h8000);
        check_val("b2b_second_ovf", ovf_d2, 1);
        settle();

        // Reset during RUN cycle 2
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", if4.busy, 0);
        check_val("abort_done", if4.done, 0);
        check_val("abort_s", if4.s, 0);
        check_val("abort_flags", {if4.cout, if4.ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (if4.done) nd++;
        end
        check_val("abort_no_done", nd, 0);
        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
        check_val("after_abort_s", if4.s, 16'h2201);
        check_val("after_abort_lat", lat4, 4);

        // Random sweep across all three digit widths
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            logic rc, rs;
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            exp_q.push_back(model(ra, rb, rc, rs));
            run_op(ra, rb, rc, rs);
            e = exp_q.pop_front();
            check_val($sformatf("rnd%0d_d1", i), {if1.cout, if1.ovf, if1.s}, e);
            check_val($sformatf("rnd%0d_d4", i), {if4.cout, if4.ovf, if4.s}, e);
            check_val($sformatf("rnd%0d_d16", i), {if16.cout, if16.ovf, if16.s}, e);
            check_val($sformatf("rnd%0d_lat", i), {8'(lat1), 8'(lat4), 8'(lat16)}, {8'd16, 8'd4, 8'd1});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
